// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the bit-serial adder controller
//
// Purpose : state encoding, default operand width and counter sizing shared by
//           the interface, the controller and the bench.
// Ports   : none (package).
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    // Encoding 2'd3 is unused; the controller treats it as IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter width for an arbitrary legal WIDTH (2..16); never narrower than 1 bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - start/busy/done handshake bundle for the serial adder
//
// Purpose : groups the host-side handshake, operands and result of serial_adder_ctrl.
// Signals : start, a, b, cin  (host -> adder)
//           busy, done, sum, cout (adder -> host)
// Modports: master = host side, slave = adder side.
interface serial_adder_ctrl_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// rtl/serial_adder_ctrl_full_adder.sv - one-bit full-adder datapath cell
//
// Purpose : purely combinational {co,s} = x + y + ci.
// Ports   : x, y, ci (in, 1 bit each); s, co (out, 1 bit each).
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial addition controller driving a single full-adder cell
//
// Purpose : adds two WIDTH-bit operands plus carry-in one bit per clock, LSB first,
//           through one shared full_adder; reports the result with a done pulse.
// Ports   : clk   - clock, rising edge
//           reset - synchronous, active-high
//           bus   - serial_adder_ctrl_if.slave (start/a/b/cin in, busy/done/sum/cout out)
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_adder_ctrl_if.slave   bus
);

    localparam int              CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   r_sr;
    logic               carry_q;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               busy_q;
    logic               done_q;

    logic               fa_s;
    logic               fa_c;

    full_adder u_fa (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            r_sr    <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                // DONE accepts a new start exactly like IDLE so back-to-back
                // operation costs no extra cycle.
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sr    <= bus.a;
                        b_sr    <= bus.b;
                        carry_q <= bus.cin;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        state   <= S_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state   <= S_IDLE;
                    end
                end

                S_RUN: begin
                    a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
                    r_sr    <= {fa_s, r_sr[WIDTH-1:1]};
                    carry_q <= fa_c;
                    cnt     <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        // The last sum bit is still on the cell output, so the
                        // visible result takes it directly rather than from r_sr.
                        sum_q  <= {fa_s, r_sr[WIDTH-1:1]};
                        cout_q <= fa_c;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                end

                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl (WIDTH=8)
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic clk;
    logic reset;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an accepted start produces {cout,sum} = a + b + cin,
    // published W+1 edges after acceptance; busy covers the W edges in between.
    logic         m_busy, m_done, m_cout;
    logic [W-1:0] m_sum;
    logic [W:0]   m_pending;
    int           m_left;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_done = 0; m_sum = '0; m_cout = 0; m_left = 0;
        end else if (m_left == 0) begin
            m_done = 0;
            if (bus.start) begin
                m_pending = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.cin};
                m_left    = W;
                m_busy    = 1;
            end else begin
                m_busy = 0;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                {m_cout, m_sum} = m_pending;
                m_done = 1;
                m_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("done", 32'(bus.done), 32'(m_done));
        check("sum",  32'(bus.sum),  32'(m_sum));
        check("cout", 32'(bus.cout), 32'(m_cout));
        check("busy_and_done", 32'(bus.busy & bus.done), 32'd0);
    end

    // Launch one addition, wait (bounded) for done, then pin latency and result.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input logic [W-1:0] prev_sum, input logic [W-1:0] exp_sum,
                          input logic exp_cout, input string nm);
        int lat;
        bus.a = ta; bus.b = tb_v; bus.cin = tc; bus.start = 1'b1;
        @(negedge clk);
        lat = 1;
        bus.start = 1'b0;
        bus.a = ~ta; bus.b = ~tb_v; bus.cin = ~tc;
        while (!bus.done && lat < 40) begin
            if (lat == 4) check({nm, "_held_sum"}, 32'(bus.sum), 32'(prev_sum));
            @(negedge clk);
            lat++;
        end
        check({nm, "_latency"}, 32'(lat), 32'(W + 1));
        check({nm, "_sum"}, 32'(bus.sum), 32'(exp_sum));
        check({nm, "_cout"}, 32'(bus.cout), 32'(exp_cout));
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done) n++;
        end
    endtask

    initial begin
        int n;
        int lat;
        int t_done[$];
        reset = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum",  32'(bus.sum),  32'h00);
        check("rst_cout", 32'(bus.cout), 32'd0);
        reset = 1'b0;
        count_done(5, n);
        check("idle_no_done", 32'(n), 32'd0);

        run_op(8'h5A, 8'h33, 1'b0, 8'h00, 8'h8D, 1'b0, "basic");
        run_op(8'hFF, 8'h01, 1'b0, 8'h8D, 8'h00, 1'b1, "chain");
        run_op(8'hFF, 8'hFF, 1'b1, 8'h00, 8'hFF, 1'b1, "chain_cin");
        @(negedge clk);

        // Start while busy is ignored.
        bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.a = 8'h7F; bus.b = 8'h7F; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 3;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("busy_start_latency", 32'(lat), 32'(W + 1));
        check("busy_start_sum",  32'(bus.sum),  32'h30);
        check("busy_start_cout", 32'(bus.cout), 32'd0);
        count_done(20, n);
        check("busy_start_single_done", 32'(n), 32'd0);

        // Reset in the middle of a run.
        bus.a = 8'h55; bus.b = 8'h0F; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_sum",  32'(bus.sum),  32'h00);
        count_done(12, n);
        check("midrst_no_done", 32'(n), 32'd0);
        run_op(8'h01, 8'h02, 1'b0, 8'h00, 8'h03, 1'b0, "after_rst");
        @(negedge clk);

        // Back-to-back with start held high.
        bus.a = 8'h80; bus.b = 8'h80; bus.cin = 1'b0; bus.start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                t_done.push_back(i);
                check("b2b_sum",  32'(bus.sum),  32'h00);
                check("b2b_cout", 32'(bus.cout), 32'd1);
            end
        end
        bus.start = 1'b0;
        check("b2b_count", 32'(t_done.size()), 32'd4);
        for (int i = 1; i < t_done.size(); i++)
            check("b2b_interval", 32'(t_done[i] - t_done[i-1]), 32'(W + 1));
        if (t_done.size() > 0) check("b2b_first", 32'(t_done[0]), 32'(W + 1));
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
